// File: rtl/alu_op_sequencer.sv
// Initiator for a registered ALU: one command in flight, fixed-latency capture, valid/ready response.
// Optional operand chaining (A <- last result) is built when ALU_SEQ_CHAIN_EN is defined.
module alu_op_sequencer #(
  parameter int NUMBITS     = 16,
  parameter int ALU_LATENCY = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [NUMBITS-1:0] cmd_a,
  input  logic [NUMBITS-1:0] cmd_b,
  input  logic [2:0]         cmd_opcode,
  input  logic               cmd_chain,
  output logic [NUMBITS-1:0] alu_a,
  output logic [NUMBITS-1:0] alu_b,
  output logic [2:0]         alu_opcode,
  input  logic [NUMBITS-1:0] alu_result,
  input  logic               alu_carryout,
  input  logic               alu_overflow,
  input  logic               alu_zero,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [NUMBITS-1:0] rsp_result,
  output logic               rsp_carryout,
  output logic               rsp_overflow,
  output logic               rsp_zero,
  output logic               busy
);

  localparam logic [3:0] LAT = 4'(ALU_LATENCY);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [NUMBITS-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]         op_q, op_d;
  logic [NUMBITS-1:0] res_q, res_d;
  logic               c_q, c_d, v_q, v_d, z_q, z_d;
  logic [NUMBITS-1:0] a_sel;

`ifdef ALU_SEQ_CHAIN_EN
  // The captured result register doubles as the chain accumulator: it holds the
  // last captured result and clears on reset.
  assign a_sel = cmd_chain ? res_q : cmd_a;
`else
  logic unused_chain;
  assign unused_chain = cmd_chain;
  assign a_sel        = cmd_a;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    c_d     = c_q;
    v_d     = v_q;
    z_d     = z_q;
    case (state_q)
      S_IDLE: if (cmd_valid) begin
        a_d     = a_sel;
        b_d     = cmd_b;
        op_d    = cmd_opcode;
        cnt_d   = LAT;
        state_d = S_WAIT;
      end
      S_WAIT: if (cnt_q != 4'd0) begin
        cnt_d = cnt_q - 4'd1;
      end else begin
        res_d   = alu_result;
        c_d     = alu_carryout;
        v_d     = alu_overflow;
        z_d     = alu_zero;
        state_d = S_RESP;
      end
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      c_q     <= c_d;
      v_q     <= v_d;
      z_q     <= z_d;
    end
  end

  assign cmd_ready    = (state_q == S_IDLE);
  assign rsp_valid    = (state_q == S_RESP);
  assign busy         = (state_q != S_IDLE);
  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign alu_opcode   = op_q;
  assign rsp_result   = res_q;
  assign rsp_carryout = c_q;
  assign rsp_overflow = v_q;
  assign rsp_zero     = z_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural registered ALU, directed scenarios and randomized ops
// against a command-level reference model (latency, result/flags, chaining accumulator).
module tb_alu_op_sequencer;
  localparam int W = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // default-latency instance
  logic         cmd_valid, cmd_ready, cmd_chain, rsp_valid, rsp_ready, busy;
  logic [W-1:0] cmd_a, cmd_b, alu_a, alu_b, alu_result, rsp_result;
  logic [2:0]   cmd_opcode, alu_opcode;
  logic         alu_carryout, alu_overflow, alu_zero, rsp_carryout, rsp_overflow, rsp_zero;

  // ALU_LATENCY=3 instance
  logic         cmd_valid3, cmd_ready3, cmd_chain3, rsp_valid3, rsp_ready3, busy3;
  logic [W-1:0] cmd_a3, cmd_b3, alu_a3, alu_b3, alu_result3, rsp_result3;
  logic [2:0]   cmd_opcode3, alu_opcode3;
  logic         alu_carryout3, alu_overflow3, alu_zero3, rsp_carryout3, rsp_overflow3, rsp_zero3;

  alu_op_sequencer #(.NUMBITS(W), .ALU_LATENCY(1)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_opcode(cmd_opcode), .cmd_chain(cmd_chain),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_carryout(alu_carryout), .alu_overflow(alu_overflow),
    .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carryout(rsp_carryout), .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero),
    .busy(busy)
  );

  alu_op_sequencer #(.NUMBITS(W), .ALU_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_a(cmd_a3), .cmd_b(cmd_b3),
    .cmd_opcode(cmd_opcode3), .cmd_chain(cmd_chain3),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_opcode(alu_opcode3),
    .alu_result(alu_result3), .alu_carryout(alu_carryout3), .alu_overflow(alu_overflow3),
    .alu_zero(alu_zero3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_result(rsp_result3),
    .rsp_carryout(rsp_carryout3), .rsp_overflow(rsp_overflow3), .rsp_zero(rsp_zero3),
    .busy(busy3)
  );

  // ALU behaviour, packed as {carry, overflow, zero, result}
  function automatic logic [W+2:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [2:0] op);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         c, v;
    c = 1'b0; v = 1'b0; s = '0; r = '0;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[W-1:0]; c = s[W];
                  v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
      3'd1: begin s = {1'b0, a} - {1'b0, b}; r = s[W-1:0]; c = s[W];
                  v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = ~(a | b);
      3'd5: r = ~(a & b);
      3'd6: r = a ^ b;
      default: r = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
    endcase
    return {c, v, (r == '0), r};
  endfunction

  // registered ALU models: 1 stage and 3 stages
  logic [W+2:0] alu1_q = '0;
  logic [W+2:0] p0 = '0, p1 = '0, p2 = '0;
  always @(posedge clk) begin
    alu1_q <= alu_fn(alu_a, alu_b, alu_opcode);
    p0     <= alu_fn(alu_a3, alu_b3, alu_opcode3);
    p1     <= p0;
    p2     <= p1;
  end
  assign {alu_carryout, alu_overflow, alu_zero, alu_result}     = alu1_q;
  assign {alu_carryout3, alu_overflow3, alu_zero3, alu_result3} = p2;

  logic [W-1:0] acc_m;  // reference accumulator: last completed result

  function automatic logic [W-1:0] eff_a(input logic [W-1:0] a, input logic ch);
`ifdef ALU_SEQ_CHAIN_EN
    return ch ? acc_m : a;
`else
    return a;
`endif
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                        input logic ch, input int hold, output int lat, output logic [W+2:0] got);
    int n;
    n = 0;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    cmd_a = a; cmd_b = b; cmd_opcode = op; cmd_chain = ch; cmd_valid = 1'b1; rsp_ready = 1'b0;
    tick();
    cmd_valid = 1'b0; cmd_a = 16'($urandom); cmd_b = 16'($urandom); cmd_chain = 1'($urandom);
    lat = 0;
    while (!rsp_valid && lat < 50) begin tick(); lat++; end
    got = {rsp_carryout, rsp_overflow, rsp_zero, rsp_result};
    repeat (hold) tick();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    total++;
    if (lat >= 50 || n >= 50) begin
      bad++; $display("FAIL op_timeout got lat=%0d wait=%0d exp below 50", lat, n);
    end
  endtask

  task automatic test_reset();
    cmd_valid = 0; cmd_a = '0; cmd_b = '0; cmd_opcode = '0; cmd_chain = 0; rsp_ready = 0;
    cmd_valid3 = 0; cmd_a3 = '0; cmd_b3 = '0; cmd_opcode3 = '0; cmd_chain3 = 0; rsp_ready3 = 1;
    #2 reset = 1'b0;
    #1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    total++; if ({rsp_valid, busy} !== 2'b00) begin bad++; $display("FAIL reset_valid_busy got=%b exp=00", {rsp_valid, busy}); end
    total++; if ({alu_a, alu_b, alu_opcode} !== '0) begin bad++; $display("FAIL reset_alu got=%h/%h/%h exp=0", alu_a, alu_b, alu_opcode); end
    total++; if ({rsp_carryout, rsp_overflow, rsp_zero, rsp_result} !== '0) begin bad++; $display("FAIL reset_rsp got=%h exp=0", {rsp_carryout, rsp_overflow, rsp_zero, rsp_result}); end
    total++; if ({cmd_ready3, rsp_valid3, busy3} !== 3'b100) begin bad++; $display("FAIL reset_dut3 got=%b exp=100", {cmd_ready3, rsp_valid3, busy3}); end
    tick(); tick();
    reset = 1'b1;
    tick();
    acc_m = '0;
  endtask

  task automatic test_add();
    int lat; logic [W+2:0] got;
    run_op(16'hFFFF, 16'h0001, 3'b000, 1'b0, 0, lat, got);
    total++; if (lat != 2) begin bad++; $display("FAIL add_latency got=%0d exp=2", lat); end
    total++; if (got !== 19'h50000) begin bad++; $display("FAIL add_result got=%h exp=50000", got); end
    acc_m = 16'h0000;
  endtask

  task automatic test_logic();
    rsp_ready = 1'b1;
    cmd_a = 16'h00F0; cmd_b = 16'h00FF; cmd_opcode = 3'b110; cmd_chain = 0; cmd_valid = 1;
    tick();
    cmd_valid = 0;
    total++; if ({cmd_ready, busy} !== 2'b01) begin bad++; $display("FAIL logic_wait1 ready_busy got=%b exp=01", {cmd_ready, busy}); end
    tick();
    total++; if ({cmd_ready, rsp_valid} !== 2'b00) begin bad++; $display("FAIL logic_wait2 ready_valid got=%b exp=00", {cmd_ready, rsp_valid}); end
    tick();
    total++; if ({cmd_ready, rsp_valid} !== 2'b01) begin bad++; $display("FAIL logic_resp ready_valid got=%b exp=01", {cmd_ready, rsp_valid}); end
    total++; if ({rsp_carryout, rsp_overflow, rsp_zero, rsp_result} !== 19'h0000F) begin bad++; $display("FAIL logic_result got=%h exp=0000f", {rsp_carryout, rsp_overflow, rsp_zero, rsp_result}); end
    tick();
    total++; if ({cmd_ready, rsp_valid} !== 2'b10) begin bad++; $display("FAIL logic_after_hs ready_valid got=%b exp=10", {cmd_ready, rsp_valid}); end
    rsp_ready = 1'b0;
    acc_m = 16'h000F;
  endtask

  task automatic test_backpressure();
    int n; logic [W+2:0] got;
    rsp_ready = 0;
    cmd_a = 16'h1234; cmd_b = 16'h0101; cmd_opcode = 3'b000; cmd_chain = 0; cmd_valid = 1;
    tick();
    cmd_a = 16'h0005; cmd_b = 16'h0003; cmd_opcode = 3'b001;  // second command held valid
    n = 0;
    while (!rsp_valid && n < 50) begin tick(); n++; end
    got = {rsp_carryout, rsp_overflow, rsp_zero, rsp_result};
    total++; if (got !== 19'h01335) begin bad++; $display("FAIL bp_first_result got=%h exp=01335", got); end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || alu_a !== 16'h1234 ||
          {rsp_carryout, rsp_overflow, rsp_zero, rsp_result} !== got) begin
        bad++; $display("FAIL bp_hold cyc=%0d got v=%b r=%b a=%h rsp=%h exp v=1 r=0 a=1234 rsp=%h",
                        i, rsp_valid, cmd_ready, alu_a, {rsp_carryout, rsp_overflow, rsp_zero, rsp_result}, got);
      end
    end
    rsp_ready = 1;
    tick();
    total++; if ({rsp_valid, cmd_ready} !== 2'b01 || rsp_result !== 16'h1335) begin bad++; $display("FAIL bp_handshake got v_r=%b res=%h exp 01 1335", {rsp_valid, cmd_ready}, rsp_result); end
    tick();
    cmd_valid = 0;
    total++; if (alu_a !== 16'h0005 || alu_opcode !== 3'b001 || cmd_ready !== 1'b0) begin bad++; $display("FAIL bp_second_accept got a=%h op=%b r=%b exp 0005 001 0", alu_a, alu_opcode, cmd_ready); end
    n = 0;
    while (!rsp_valid && n < 50) begin tick(); n++; end
    total++; if (n != 2 || {rsp_carryout, rsp_overflow, rsp_zero, rsp_result} !== 19'h00002) begin bad++; $display("FAIL bp_second_result got lat=%0d rsp=%h exp 2 00002", n, {rsp_carryout, rsp_overflow, rsp_zero, rsp_result}); end
    tick();
    rsp_ready = 0;
    acc_m = 16'h0002;
  endtask

  task automatic test_reset_wait();
    cmd_a = 16'h0003; cmd_b = 16'h0004; cmd_opcode = 3'b000; cmd_chain = 0; cmd_valid = 1; rsp_ready = 1;
    tick();
    cmd_valid = 0;
    tick();
    reset = 1'b0;
    #1;
    total++; if ({cmd_ready, rsp_valid, busy} !== 3'b100) begin bad++; $display("FAIL rstwait_ctrl got=%b exp=100", {cmd_ready, rsp_valid, busy}); end
    total++; if (alu_a !== 16'h0000 || alu_b !== 16'h0000) begin bad++; $display("FAIL rstwait_alu got a=%h b=%h exp 0000", alu_a, alu_b); end
    tick();
    reset = 1'b1;
    acc_m = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL rstwait_after cyc=%0d got v=%b r=%b exp v=0 r=1", i, rsp_valid, cmd_ready); end
    end
    rsp_ready = 0;
  endtask

  task automatic test_chain();
    int lat; logic [W+2:0] got;
    run_op(16'h0003, 16'h0004, 3'b000, 1'b0, 0, lat, got);
    total++; if (got !== 19'h00007) begin bad++; $display("FAIL chain_first got=%h exp=00007", got); end
    acc_m = 16'h0007;
    run_op(16'h0001, 16'h0010, 3'b000, 1'b1, 1, lat, got);
`ifdef ALU_SEQ_CHAIN_EN
    total++; if (got !== 19'h00017) begin bad++; $display("FAIL chain_second got=%h exp=00017", got); end
    acc_m = 16'h0017;
`else
    total++; if (got !== 19'h00011) begin bad++; $display("FAIL chain_second got=%h exp=00011", got); end
    acc_m = 16'h0011;
`endif
  endtask

  task automatic test_random();
    int lat; logic [W+2:0] got, exp_v;
    logic [W-1:0] a, b; logic [2:0] op; logic ch;
    for (int i = 0; i < 30; i++) begin
      a = 16'($urandom); b = 16'($urandom); op = 3'($urandom); ch = 1'($urandom);
      if (i % 5 == 0) b = a;  // exercise zero/equal cases
      exp_v = alu_fn(eff_a(a, ch), b, op);
      run_op(a, b, op, ch, int'($urandom_range(0, 3)), lat, got);
      total++;
      if (lat != 2 || got !== exp_v) begin
        bad++; $display("FAIL random i=%0d got lat=%0d rsp=%h exp lat=2 rsp=%h (a=%h b=%h op=%0d ch=%b)",
                        i, lat, got, exp_v, a, b, op, ch);
      end
      acc_m = exp_v[W-1:0];
    end
  endtask

  task automatic test_latency3();
    int n;
    n = 0;
    while (!cmd_ready3 && n < 50) begin tick(); n++; end
    cmd_a3 = 16'h1111; cmd_b3 = 16'h2222; cmd_opcode3 = 3'b000; cmd_valid3 = 1; rsp_ready3 = 1;
    tick();
    cmd_valid3 = 0;
    n = 0;
    while (!rsp_valid3 && n < 50) begin tick(); n++; end
    total++; if (n != 4) begin bad++; $display("FAIL lat3_edge got=%0d exp=4", n); end
    total++; if ({rsp_carryout3, rsp_overflow3, rsp_zero3, rsp_result3} !== 19'h03333) begin bad++; $display("FAIL lat3_result got=%h exp=03333", {rsp_carryout3, rsp_overflow3, rsp_zero3, rsp_result3}); end
    tick();
    total++; if ({rsp_valid3, cmd_ready3} !== 2'b01) begin bad++; $display("FAIL lat3_handshake got=%b exp=01", {rsp_valid3, cmd_ready3}); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_logic();
    test_backpressure();
    test_reset_wait();
    test_chain();
    test_random();
    test_latency3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
